pipe_stage_skid: RTL

Parametrised, elastic replacement for the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload of DATA_W bits.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream ready path stays short.
- Still honours the global stall vector from the control unit and adds a synchronous flush.
- One instance sits between each pair of stages; STAGE_IDX selects which stall bits apply.

---
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage pipeline register: valid/ready handshake over a 2-entry skid buffer,
// honouring the global stall vector and a synchronous flush. Optional macro: PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W     = 72,
  parameter int unsigned        STALL_W    = 6,
  parameter int unsigned        STAGE_IDX  = 3,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [31:0]        perf_bubble_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;

  logic hold_in, hold_out;
  logic in_xfer, out_xfer;

  assign hold_in  = stall[STAGE_IDX];
  assign hold_out = stall[STAGE_IDX+1];

  // Only two stall bits matter to this stage; the rest are intentionally ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign in_ready  = (state_q != StFull) && !hold_in && !flush;
  assign out_valid = (state_q != StEmpty) && !hold_out;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A head that transfers this cycle has already been seen downstream.
      state_d = StEmpty;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = StBusy;
          end
        end
        StBusy: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (out_xfer) begin
            main_d  = BUBBLE_VAL;
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_xfer) begin
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
            state_d = StBusy;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Counts edges with nothing offered downstream; wraps naturally, survives flush.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (!out_valid) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_bubble_cnt = perf_cnt_q;
`else
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule
